// File: rtl/pwm_array.sv
// pwm_array: multi-channel PWM generator with brightness scaling and period-aligned duty updates
module pwm_array #(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int PWM_FREQ = 20_480,
  parameter int BIT_W = 8,
  parameter int CHANNELS = 3,
  parameter int STAGGER = 0
) (
  input logic clk_in,
  input logic n_reset_in,
  input logic enable_in,
  input logic [CHANNELS*BIT_W-1:0] duty_in,
  input logic duty_valid_in,
  output logic duty_ready_out,
  input logic [BIT_W-1:0] brightness_in,
  output logic [CHANNELS-1:0] pwm_out,
  output logic period_start_out
);
  localparam longint UC_RAW = longint'(SYS_CLK_FREQ) / (longint'(PWM_FREQ) << BIT_W);
  localparam int UC = UC_RAW < 1 ? 1 : int'(UC_RAW);
  localparam int PW = UC > 1 ? $clog2(UC) : 1;
  localparam int OFS = (1 << BIT_W) / CHANNELS;
  logic [PW-1:0] presc;
  logic [BIT_W-1:0] phase, bright;
  logic [CHANNELS*BIT_W-1:0] pend, act;
  logic flag, en_q, start_q, tick, bnd, apply, accept;
  logic [CHANNELS-1:0] pwm_d;
  always_comb begin
    tick = enable_in && presc == PW'(UC - 1);
    bnd = tick && &phase;
    apply = enable_in ? bnd : 1'b1;
    accept = duty_valid_in && !flag;
  end
  assign duty_ready_out = !flag;
  assign period_start_out = n_reset_in && enable_in && (start_q || !en_q);
  for (genvar g = 0; g < CHANNELS; g++) begin : ch
    logic [BIT_W-1:0] d, e, p;
    logic [2*BIT_W-1:0] prod;
    assign d = act[g*BIT_W +: BIT_W];
    assign prod = {{BIT_W{1'b0}}, d} * {{BIT_W{1'b0}}, bright};
    assign e = &bright ? d : prod[2*BIT_W-1:BIT_W];
    assign p = phase + (STAGGER != 0 ? BIT_W'(g * OFS) : BIT_W'(0));
    assign pwm_d[g] = e == '0 ? 1'b0 : &e ? 1'b1 : p < e;
  end
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      presc <= '0;
      phase <= '0;
      pend <= '0;
      act <= '0;
      bright <= '0;
      flag <= 1'b0;
      en_q <= 1'b0;
      start_q <= 1'b0;
      pwm_out <= '0;
    end else begin
      presc <= tick || !enable_in ? '0 : presc + 1'b1;
      phase <= !enable_in ? '0 : phase + BIT_W'(tick);
      en_q <= enable_in;
      start_q <= bnd;
      pwm_out <= enable_in ? pwm_d : '0;
      if (apply) bright <= brightness_in;
      if (apply && flag) act <= pend;
      if (accept) pend <= duty_in;
      flag <= accept || (flag && !apply);
    end
  end
endmodule

// File: tb/tb_pwm_array.sv
// tb_pwm_array: scoreboard bench for pwm_array using a 64-cycle period configuration
module tb_pwm_array;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic n_reset_in, enable_in, duty_valid_in, duty_ready_out, period_start_out;
  logic [11:0] duty_in;
  logic [3:0] brightness_in;
  logic [2:0] pwm_out;
  logic en_s, valid_s, ready_s, ps_s;
  logic [15:0] duty_s;
  logic [3:0] pwm_s;
  pwm_array #(.SYS_CLK_FREQ(64_000), .PWM_FREQ(1000), .BIT_W(4), .CHANNELS(3), .STAGGER(0)) dut (
    .clk_in(clk_in), .n_reset_in(n_reset_in), .enable_in(enable_in), .duty_in(duty_in),
    .duty_valid_in(duty_valid_in), .duty_ready_out(duty_ready_out), .brightness_in(brightness_in),
    .pwm_out(pwm_out), .period_start_out(period_start_out)
  );
  pwm_array #(.SYS_CLK_FREQ(64_000), .PWM_FREQ(1000), .BIT_W(4), .CHANNELS(4), .STAGGER(1)) dut_s (
    .clk_in(clk_in), .n_reset_in(n_reset_in), .enable_in(en_s), .duty_in(duty_s),
    .duty_valid_in(valid_s), .duty_ready_out(ready_s), .brightness_in(brightness_in),
    .pwm_out(pwm_s), .period_start_out(ps_s)
  );
  typedef struct {string name; logic [63:0] wave;} exp_t;
  exp_t sb[$];
  int cq[$];
  int checks = 0;
  int errors = 0;
  logic [63:0] wv [4];
  int starts;
  function automatic int eff_of(int d, int b);
    return b == 15 ? d : (d * b) >> 4;
  endfunction
  function automatic logic [63:0] exp_wave(int eff, int offs);
    logic [63:0] w;
    int ph;
    for (int k = 0; k < 64; k++) begin
      ph = ((((k + 63) % 64) / 4) + offs) % 16;
      w[k] = eff == 0 ? 1'b0 : eff == 15 ? 1'b1 : ph < eff;
    end
    return w;
  endfunction
  task automatic push3(input string tag, input logic [11:0] d, input int b);
    for (int c = 0; c < 3; c++)
      sb.push_back('{$sformatf("%s_ch%0d", tag, c), exp_wave(eff_of(int'(d[c*4 +: 4]), b), 0)});
  endtask
  task automatic write_duty(input logic [11:0] d, input int budget, output int waited);
    duty_in = d;
    duty_valid_in = 1'b1;
    waited = 0;
    #1;
    while (!duty_ready_out && waited < budget) begin
      @(negedge clk_in);
      #1;
      waited++;
    end
    checks++;
    if (waited >= budget) begin
      errors++;
      $display("FAIL write_timeout: ready still %b after %0d cycles, required 1", duty_ready_out, waited);
    end
    @(negedge clk_in);
    duty_valid_in = 1'b0;
  endtask
  task automatic measure(input bit stag);
    bit found;
    logic [3:0] p;
    found = 1'b0;
    starts = 0;
    for (int c = 0; c < 4; c++) wv[c] = '0;
    for (int i = 0; i < 200 && !found; i++) begin
      #1;
      if ((stag ? ps_s : period_start_out) === 1'b1) found = 1'b1;
      else @(negedge clk_in);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL period_start_wait: no period start in 200 cycles, required one");
      return;
    end
    for (int k = 0; k < 64; k++) begin
      p = stag ? pwm_s : {1'b0, pwm_out};
      for (int c = 0; c < 4; c++) wv[c][k] = p[c];
      starts += int'(stag ? ps_s : period_start_out);
      @(negedge clk_in);
      if (k < 63) #1;
    end
  endtask
  task automatic test_reset;
    n_reset_in = 1'b0;
    enable_in = 1'b1;
    duty_valid_in = 1'b1;
    duty_in = '1;
    brightness_in = 4'd15;
    en_s = 1'b0;
    valid_s = 1'b0;
    duty_s = '0;
    repeat (3) @(negedge clk_in);
    #1;
    checks++;
    if (pwm_out !== 3'b000) begin errors++; $display("FAIL reset_pwm: got %b required 000", pwm_out); end
    checks++;
    if (period_start_out !== 1'b0) begin errors++; $display("FAIL reset_start: got %b required 0", period_start_out); end
    checks++;
    if (duty_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", duty_ready_out); end
    @(negedge clk_in);
    duty_valid_in = 1'b0;
    enable_in = 1'b0;
    n_reset_in = 1'b1;
    @(negedge clk_in);
    #1;
    checks++;
    if ({duty_ready_out, period_start_out, pwm_out} !== 5'b10000) begin
      errors++;
      $display("FAIL post_reset_idle: got ready/start/pwm %b required 10000", {duty_ready_out, period_start_out, pwm_out});
    end
    @(negedge clk_in);
  endtask
  task automatic test_basic;
    int w;
    exp_t e;
    logic [11:0] d;
    d = {4'd8, 4'd8, 4'd8};
    write_duty(d, 20, w);
    push3("basic", d, 15);
    @(negedge clk_in);
    #1;
    checks++;
    if (duty_ready_out !== 1'b1) begin errors++; $display("FAIL disabled_apply: ready %b required 1", duty_ready_out); end
    @(negedge clk_in);
    enable_in = 1'b1;
    #1;
    checks++;
    if (period_start_out !== 1'b1) begin errors++; $display("FAIL first_enabled_start: got %b required 1", period_start_out); end
    measure(0);
    checks++;
    if (starts !== 1) begin errors++; $display("FAIL starts_per_period: got %0d required 1", starts); end
    checks++;
    if ({wv[2][1:0], wv[1][1:0], wv[0][1:0]} !== 6'b101010) begin
      errors++;
      $display("FAIL rise_after_start: got %b required 101010", {wv[2][1:0], wv[1][1:0], wv[0][1:0]});
    end
    measure(0);
    for (int c = 0; c < 3; c++) begin
      e = sb.pop_front();
      checks++;
      if (wv[c] !== e.wave) begin errors++; $display("FAIL %s: got %h required %h", e.name, wv[c], e.wave); end
    end
  endtask
  task automatic test_fixed;
    int w;
    exp_t e;
    logic [11:0] d;
    d = {4'd1, 4'd15, 4'd0};
    write_duty(d, 100, w);
    push3("fixed", d, 15);
    measure(0);
    measure(0);
    for (int c = 0; c < 3; c++) begin
      e = sb.pop_front();
      checks++;
      if (wv[c] !== e.wave) begin errors++; $display("FAIL %s: got %h required %h", e.name, wv[c], e.wave); end
    end
  endtask
  task automatic test_update;
    int w;
    int hi [3];
    int x;
    exp_t e;
    logic [11:0] d, d2;
    d = {4'd12, 4'd12, 4'd12};
    d2 = {4'd4, 4'd4, 4'd4};
    repeat (20) @(negedge clk_in);
    write_duty(d, 100, w);
    for (int c = 0; c < 3; c++) cq.push_back(48);
    #1;
    checks++;
    if (duty_ready_out !== 1'b0) begin errors++; $display("FAIL ready_low_pending: got %b required 0", duty_ready_out); end
    checks++;
    if (pwm_out !== 3'b010) begin errors++; $display("FAIL old_duty_kept: got %b required 010", pwm_out); end
    @(negedge clk_in);
    write_duty(d2, 100, w);
    push3("update2", d2, 15);
    checks++;
    if (w !== 42) begin errors++; $display("FAIL second_write_wait: got %0d cycles required 42", w); end
    for (int c = 0; c < 3; c++) hi[c] = 0;
    for (int k = 0; k < 63; k++) begin
      #1;
      for (int c = 0; c < 3; c++) hi[c] += int'(pwm_out[c]);
      @(negedge clk_in);
    end
    for (int c = 0; c < 3; c++) begin
      x = cq.pop_front();
      checks++;
      if (hi[c] !== x) begin errors++; $display("FAIL update_high_ch%0d: got %0d required %0d", c, hi[c], x); end
    end
    measure(0);
    for (int c = 0; c < 3; c++) begin
      e = sb.pop_front();
      checks++;
      if (wv[c] !== e.wave) begin errors++; $display("FAIL %s: got %h required %h", e.name, wv[c], e.wave); end
    end
  endtask
  task automatic test_bright;
    int w;
    int hi [3];
    int x;
    exp_t e;
    logic [11:0] d;
    d = {4'd10, 4'd10, 4'd10};
    brightness_in = 4'd8;
    write_duty(d, 100, w);
    push3("bright8", d, 8);
    measure(0);
    for (int c = 0; c < 3; c++) begin
      e = sb.pop_front();
      checks++;
      if (wv[c] !== e.wave) begin errors++; $display("FAIL %s: got %h required %h", e.name, wv[c], e.wave); end
    end
    repeat (32) @(negedge clk_in);
    brightness_in = 4'd15;
    for (int c = 0; c < 3; c++) cq.push_back(0);
    push3("bright15", d, 15);
    for (int c = 0; c < 3; c++) hi[c] = 0;
    for (int k = 0; k < 32; k++) begin
      #1;
      for (int c = 0; c < 3; c++) hi[c] += int'(pwm_out[c]);
      @(negedge clk_in);
    end
    for (int c = 0; c < 3; c++) begin
      x = cq.pop_front();
      checks++;
      if (hi[c] !== x) begin errors++; $display("FAIL bright_midperiod_ch%0d: got %0d required %0d", c, hi[c], x); end
    end
    measure(0);
    for (int c = 0; c < 3; c++) begin
      e = sb.pop_front();
      checks++;
      if (wv[c] !== e.wave) begin errors++; $display("FAIL %s: got %h required %h", e.name, wv[c], e.wave); end
    end
  endtask
  task automatic test_reset_mid;
    int w;
    int bad;
    exp_t e;
    logic [11:0] d;
    d = {4'd8, 4'd0, 4'd15};
    repeat (36) @(negedge clk_in);
    n_reset_in = 1'b0;
    enable_in = 1'b0;
    @(negedge clk_in);
    n_reset_in = 1'b1;
    #1;
    checks++;
    if ({duty_ready_out, period_start_out, pwm_out} !== 5'b10000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got ready/start/pwm %b required 10000", {duty_ready_out, period_start_out, pwm_out});
    end
    @(negedge clk_in);
    write_duty(d, 5, w);
    push3("mid", d, 15);
    @(negedge clk_in);
    #1;
    checks++;
    if (duty_ready_out !== 1'b1) begin errors++; $display("FAIL disabled_apply2: ready %b required 1", duty_ready_out); end
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      #1;
      bad += int'(pwm_out != 3'b000 || period_start_out != 1'b0);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL disabled_outputs: %0d active cycles required 0", bad); end
    @(negedge clk_in);
    enable_in = 1'b1;
    #1;
    checks++;
    if (period_start_out !== 1'b1) begin errors++; $display("FAIL start_after_reset: got %b required 1", period_start_out); end
    measure(0);
    measure(0);
    for (int c = 0; c < 3; c++) begin
      e = sb.pop_front();
      checks++;
      if (wv[c] !== e.wave) begin errors++; $display("FAIL %s: got %h required %h", e.name, wv[c], e.wave); end
    end
  endtask
  task automatic test_stagger;
    exp_t e;
    duty_s = {4{4'd8}};
    valid_s = 1'b1;
    #1;
    checks++;
    if (ready_s !== 1'b1) begin errors++; $display("FAIL stagger_ready: got %b required 1", ready_s); end
    @(negedge clk_in);
    valid_s = 1'b0;
    for (int c = 0; c < 4; c++) sb.push_back('{$sformatf("stagger_ch%0d", c), exp_wave(8, 4 * c)});
    @(negedge clk_in);
    en_s = 1'b1;
    measure(1);
    measure(1);
    for (int c = 0; c < 4; c++) begin
      e = sb.pop_front();
      checks++;
      if (wv[c] !== e.wave) begin errors++; $display("FAIL %s: got %h required %h", e.name, wv[c], e.wave); end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_fixed;
    test_update;
    test_bright;
    test_reset_mid;
    test_stagger;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_array.md
PWM_ARRAY -- requirements
Module: pwm_array

Interface
REQ-001 Parameter SYS_CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter PWM_FREQ, default 20_480, PWM period frequency in Hz.
REQ-003 Parameter BIT_W, default 8, duty and brightness width.
REQ-004 Parameter CHANNELS, default 3, number of PWM outputs (1..32).
REQ-005 Parameter STAGGER, default 0; 1 = per-channel phase offset.
REQ-006 clk_in  input  1  single system clock; all logic on rising edge.
REQ-007 n_reset_in  input  1  synchronous, active-low reset.
REQ-008 enable_in  input  1  run enable.
REQ-009 duty_in  input  CHANNELS*BIT_W  packed duties, channel c at bits [c*BIT_W +: BIT_W].
REQ-010 duty_valid_in  input  1  duty_in valid.
REQ-011 duty_ready_out  output  1  block can accept duty_in.
REQ-012 brightness_in  input  BIT_W  global brightness scale.
REQ-013 pwm_out  output  CHANNELS  registered PWM outputs.
REQ-014 period_start_out  output  1  one-cycle pulse at each period start.

Function
REQ-015 UNIT_COUNTS = SYS_CLK_FREQ/(PWM_FREQ*2^BIT_W), integer division; values below 1 SHALL be clamped to 1.
REQ-016 Prescaler SHALL count 0..UNIT_COUNTS-1 while enabled, asserting tick on terminal count and wrapping to 0.
REQ-017 Phase counter (BIT_W bits) SHALL increment on tick, wrapping 2^BIT_W-1 -> 0; period = UNIT_COUNTS*2^BIT_W cycles.
REQ-018 Boundary = tick with phase at 2^BIT_W-1; period_start_out SHALL be 1 in the cycle phase becomes 0, else 0.
REQ-019 Transfer on duty_valid_in & duty_ready_out: duty_in latched into a pending register, pending flag set.
REQ-020 duty_ready_out SHALL equal NOT pending flag; while low, duty_in is ignored and the source holds.
REQ-021 At a boundary: pending (if set) copied to active duties and flag cleared; brightness_in sampled into active brightness unconditionally.
REQ-022 Transfer coinciding with a boundary (flag previously clear) SHALL land in pending and apply at the following boundary.
REQ-023 Effective duty per channel: active brightness all-ones -> eff = active duty; else eff = (duty*brightness) >> BIT_W, full 2*BIT_W-bit product.
REQ-024 Channel phase: STAGGER=0 -> phase; STAGGER=1 -> (phase + c*(2^BIT_W/CHANNELS)) mod 2^BIT_W, integer division.
REQ-025 pwm_out[c] next-cycle value: 0 if eff=0; 1 if eff=2^BIT_W-1; else (channel phase < eff).
REQ-026 pwm_out SHALL lag phase/eff changes by exactly one clock.
REQ-027 enable_in low: prescaler and phase held at 0, pwm_out 0 next cycle, period_start_out 0, no ticks.
REQ-028 While disabled, pending SHALL be applied to active the following cycle and brightness sampled every cycle; handshake stays live.
REQ-029 enable_in rising: first enabled cycle treated as period start (period_start_out=1, phase 0).
REQ-030 Active duties/brightness SHALL never change mid-period while enabled (glitch-free duty update).

Reset
REQ-031 With n_reset_in low at a rising edge: prescaler, phase, pending, active duties, active brightness, flag cleared to 0.
REQ-032 During and after reset: pwm_out=0, period_start_out=0, duty_ready_out=1; duty_valid_in ignored while in reset.
REQ-033 Reset mid-period SHALL abort the period; first enabled cycle after release is a period start per REQ-029.

Verification (BIT_W=4, CHANNELS=3, SYS_CLK_FREQ=64_000, PWM_FREQ=1000 -> UNIT_COUNTS=4, period 64 cycles)
REQ-034 All duties 8, brightness 15, enabled -> each pwm_out high 32 of 64 cycles, rising one cycle after period_start_out.
REQ-035 Duties {0,15,1}, brightness 15 -> ch0 constant 0, ch1 constant 1, ch2 high 4 cycles per period.
REQ-036 Duty write 12 at phase 5 -> duty_ready_out low until boundary, old duty kept, 48-cycle high from next period; held second write accepted the cycle after the boundary.
REQ-037 Duty 10, brightness 8 -> eff 5 -> 20 high cycles per period; brightness change mid-period takes effect next period only.
REQ-038 STAGGER=1, CHANNELS=4, all duties 8 -> channel c pulse shifted 16*c cycles (mod 64) vs channel 0, equal widths.
REQ-039 Reset pulse at phase 9, then enable_in low 10 cycles -> outputs 0 throughout, pending write applied while disabled, period_start_out on first enabled cycle.
